// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read pointer blocks.
// Latency: none, these are pure combinational functions.
// Backpressure: not applicable.
//
// The functions work on a fixed-width vector. Callers zero-extend their
// pointer into it and cast the result back down to their own width. This is
// valid because Gray<->binary conversion of a zero-extended value leaves the
// upper bits at zero.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  // FIFO depth for a given address width.
  function automatic int depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ptr.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency: STAGES clock cycles from d to q.
// Backpressure: none, it samples every cycle.
//
// Ports: clk/rst_n destination clock and async active-low reset,
//        d pointer from the source domain, q synchronised pointer.
// There is deliberately no logic between the stages.
module sync_ptr #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/wptr_full_prog.sv
// Write-side pointer and status block for the async FIFO: address, Gray pointer, level, full/almost-full/overflow.
// Latency: waddr is valid in the winc cycle; status registers one wclk edge after a write, and reads show up SYNC_STAGES+1 edges late.
// Backpressure: wfull blocks writes; a write attempted while full is dropped and sets the sticky woverflow.
//
// Ports:
//   wclk, wrst_n     write clock, async active-low reset
//   winc             write request (accepted only when wfull is low)
//   rptr             Gray read pointer from the read clock domain
//   afull_thresh     almost-full level threshold, quasi-static
//   ovf_clr          clears woverflow (a simultaneous overflow wins)
//   waddr            binary memory write address
//   wptr             registered Gray write pointer to the read domain
//   wfull            FIFO full
//   walmost_full     level >= afull_thresh
//   wlevel           conservative fill level, 0..2**ASIZE
//   woverflow        sticky write-while-full flag
module wptr_full_prog
  import fifo_pkg::*;
#(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   rptr,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic             ovf_clr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);

  localparam int             DEPTH   = depth(ASIZE);
  localparam logic [ASIZE:0] DEPTH_V = (ASIZE+1)'(DEPTH);

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbinnext;
  logic [ASIZE:0] wgraynext;
  logic [ASIZE:0] wq_rptr;
  logic [ASIZE:0] wq_rbin;
  logic [ASIZE:0] level_next;
  logic           we;
  logic           full_next;
  logic           afull_next;

  sync_ptr #(
    .WIDTH  (ASIZE + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (wq_rptr)
  );

  assign we        = winc & ~wfull;
  assign wbinnext  = wbin + (ASIZE+1)'(we);
  assign wgraynext = (ASIZE+1)'(bin2gray(PTR_MAX_W'(wbinnext)));
  assign wq_rbin   = (ASIZE+1)'(gray2bin(PTR_MAX_W'(wq_rptr)));

  // Modulo subtraction stays correct across the pointer wrap because the
  // true occupancy never exceeds DEPTH, which fits in ASIZE+1 bits.
  assign level_next = wbinnext - wq_rbin;

  // Full when the next write pointer has lapped the synchronised read
  // pointer once: top two Gray bits inverted, the rest equal.
  assign full_next  = (wgraynext == {~wq_rptr[ASIZE:ASIZE-1], wq_rptr[ASIZE-2:0]});
  assign afull_next = (level_next >= afull_thresh);

  assign waddr = wbin[ASIZE-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wlevel       <= level_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      // A new overflow takes priority over a clear in the same cycle.
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (ovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

  // The Gray full compare and the level arithmetic must always agree.
  a_full_matches_level: assert property (
    @(posedge wclk) disable iff (!wrst_n) full_next == (level_next == DEPTH_V)
  );

endmodule

// File: tb/tb_wptr_full_prog.sv
module tb_wptr_full_prog;

  localparam int ASIZE = 4;
  localparam int SYNC  = 2;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] rptr;
  logic [4:0] afull_thresh;
  logic       ovf_clr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain integer write/read counts, no pointer encoding.
  int m_wcnt;
  int m_rcnt;
  int m_lvl;
  bit m_full;
  bit m_af;
  bit m_ovf;
  int pipe [SYNC];

  function automatic logic [4:0] gray_of(input int n);
    int m;
    m = n % PMOD;
    return 5'(m ^ (m >> 1));
  endfunction

  assign rptr = gray_of(m_rcnt);

  wptr_full_prog #(.ASIZE(ASIZE), .SYNC_STAGES(SYNC)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr         (rptr),
    .afull_thresh (afull_thresh),
    .ovf_clr      (ovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_rcnt = 0; m_lvl = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    for (int i = 0; i < SYNC; i++) pipe[i] = 0;
  endtask

  // Evaluate one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int we;
    int lvl_n;
    we    = (winc && !m_full) ? 1 : 0;
    lvl_n = m_wcnt + we - pipe[SYNC-1];
    if (winc && m_full) m_ovf = 1;
    else if (ovf_clr)   m_ovf = 0;
    m_full = (lvl_n == DEPTH);
    m_af   = (lvl_n >= int'(afull_thresh));
    m_lvl  = lvl_n;
    m_wcnt += we;
    for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = m_rcnt;
  endtask

  task automatic step();
    @(posedge wclk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".waddr"},  32'(waddr),        32'(m_wcnt % DEPTH));
    chk({tag, ".wptr"},   32'(wptr),         32'(gray_of(m_wcnt)));
    chk({tag, ".wlevel"}, 32'(wlevel),       32'(m_lvl));
    chk({tag, ".wfull"},  32'(wfull),        32'(m_full));
    chk({tag, ".afull"},  32'(walmost_full), 32'(m_af));
    chk({tag, ".ovf"},    32'(woverflow),    32'(m_ovf));
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge wclk);
    #1;
    wrst_n = 1'b0;
    #1;
    chk({tag, ".rst_waddr"},  32'(waddr),        0);
    chk({tag, ".rst_wptr"},   32'(wptr),         0);
    chk({tag, ".rst_wlevel"}, 32'(wlevel),       0);
    chk({tag, ".rst_wfull"},  32'(wfull),        0);
    chk({tag, ".rst_afull"},  32'(walmost_full), 0);
    chk({tag, ".rst_ovf"},    32'(woverflow),    0);
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  typedef struct {
    bit         winc;
    bit         clr;
    int         lvl;
    bit         full;
    bit         af;
    bit         ovf;
    int         addr;
    logic [4:0] ptr;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Fill to full with afull_thresh=12, then overflow and clear.
    tbl[0]  = '{1, 0,  1, 0, 0, 0,  1, 5'b00001};
    tbl[1]  = '{1, 0,  2, 0, 0, 0,  2, 5'b00011};
    tbl[2]  = '{1, 0,  3, 0, 0, 0,  3, 5'b00010};
    tbl[3]  = '{1, 0,  4, 0, 0, 0,  4, 5'b00110};
    tbl[4]  = '{1, 0,  5, 0, 0, 0,  5, 5'b00111};
    tbl[5]  = '{1, 0,  6, 0, 0, 0,  6, 5'b00101};
    tbl[6]  = '{1, 0,  7, 0, 0, 0,  7, 5'b00100};
    tbl[7]  = '{1, 0,  8, 0, 0, 0,  8, 5'b01100};
    tbl[8]  = '{1, 0,  9, 0, 0, 0,  9, 5'b01101};
    tbl[9]  = '{1, 0, 10, 0, 0, 0, 10, 5'b01111};
    tbl[10] = '{1, 0, 11, 0, 0, 0, 11, 5'b01110};
    tbl[11] = '{1, 0, 12, 0, 1, 0, 12, 5'b01010};
    tbl[12] = '{1, 0, 13, 0, 1, 0, 13, 5'b01011};
    tbl[13] = '{1, 0, 14, 0, 1, 0, 14, 5'b01001};
    tbl[14] = '{1, 0, 15, 0, 1, 0, 15, 5'b01000};
    tbl[15] = '{1, 0, 16, 1, 1, 0,  0, 5'b11000};
    tbl[16] = '{1, 0, 16, 1, 1, 1,  0, 5'b11000};
    tbl[17] = '{1, 1, 16, 1, 1, 1,  0, 5'b11000};
    tbl[18] = '{0, 1, 16, 1, 1, 0,  0, 5'b11000};

    wrst_n       = 1'b0;
    winc         = 1'b0;
    ovf_clr      = 1'b0;
    afull_thresh = 5'd12;
    model_reset();
    do_reset("init");

    // Idle after reset.
    step();
    check_model("idle");

    for (int i = 0; i < 19; i++) begin
      winc    = tbl[i].winc;
      ovf_clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d.wlevel", i), 32'(wlevel),       32'(tbl[i].lvl));
      chk($sformatf("tbl%0d.wfull", i),  32'(wfull),        32'(tbl[i].full));
      chk($sformatf("tbl%0d.afull", i),  32'(walmost_full), 32'(tbl[i].af));
      chk($sformatf("tbl%0d.ovf", i),    32'(woverflow),    32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.waddr", i),  32'(waddr),        32'(tbl[i].addr));
      chk($sformatf("tbl%0d.wptr", i),   32'(wptr),         32'(tbl[i].ptr));
    end

    // One read becomes visible: wfull must fall on exactly the third edge.
    winc    = 1'b0;
    ovf_clr = 1'b0;
    m_rcnt  = 1;
    step();
    chk("deassert.e1_full", 32'(wfull), 1);
    step();
    chk("deassert.e2_full", 32'(wfull), 1);
    step();
    chk("deassert.e3_full", 32'(wfull), 0);
    chk("deassert.e3_lvl",  32'(wlevel), 15);
    check_model("deassert");

    // Threshold 0 forces almost-full high from the first edge after reset.
    afull_thresh = 5'd0;
    do_reset("thr0");
    step();
    chk("thr0.afull", 32'(walmost_full), 1);
    check_model("thr0");

    // Long stream with the reader trailing by five, across many wraps.
    afull_thresh = 5'd16;
    for (int i = 0; i < 100; i++) begin
      winc   = 1'b1;
      m_rcnt = (m_wcnt > 5) ? m_wcnt - 5 : 0;
      step();
      chk("wrap.lvl_le_depth", 32'(wlevel <= 5'd16), 1);
      chk("wrap.full_eq_lvl",  32'(wfull), 32'(wlevel == 5'd16));
      check_model("wrap");
    end

    // Random traffic with a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) afull_thresh = 5'($urandom_range(0, 17));
      if (i == 200) begin
        do_reset("mid");
      end
      winc    = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 7) == 0);
      if (m_rcnt < m_wcnt && $urandom_range(0, 9) < 4) m_rcnt = m_rcnt + 1;
      step();
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
